nibble_serial_alu_ctrl: RTL and testbench

//  Sequencer that runs W-bit arithmetic on the shared 4-bit parallel arithmetic unit (s1/s0-selected adder).

---
 rtl/nibble_serial_alu_ctrl.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// Runs W-bit add/subtract/transfer operations through a shared 4-bit adder unit.
// The unit handles one nibble per cycle, LSB first, and the carry is chained in a register.
module nibble_serial_alu_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [2:0]             op_i,
    input  logic [4*NIBBLES-1:0]   opa_i,
    input  logic [4*NIBBLES-1:0]   opb_i,
    output logic                   ready_o,
    output logic                   done_o,
    output logic [4*NIBBLES-1:0]   result_o,
    output logic                   flag_c_o,
    output logic                   flag_z_o,
    output logic                   flag_v_o,
    output logic                   au_s1_o,
    output logic                   au_s0_o,
    output logic [3:0]             au_a_o,
    output logic [3:0]             au_b_o,
    output logic                   au_cin_o,
    input  logic [3:0]             au_s_i,
    input  logic                   au_cout_i
);

    // state | meaning
    // IDLE  | ready for a request, unit inputs parked at zero
    // RUN   | one nibble per cycle through the unit, LSB first
    // DONE  | one-cycle done pulse, result and flags valid
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic [1:0]    sel_q, sel_d;
    logic          carry_q, carry_d;
    logic          fc_q, fc_d;
    logic          fz_q, fz_d;
    logic          fv_q, fv_d;
    logic [CW+1:0] base;
    logic          beff_msb;

    assign base = {cnt_q, 2'b00};

    // MSB of the operand the unit actually adds, used for the overflow rule
    always_comb begin
        beff_msb = 1'b0;
        case (sel_q)
            2'b00:   beff_msb = b_q[W-1];
            2'b01:   beff_msb = ~b_q[W-1];
            2'b10:   beff_msb = 1'b0;
            default: beff_msb = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        result_d = result_q;
        fc_d     = fc_q;
        fz_d     = fz_q;
        fv_d     = fv_q;
        au_a_o   = 4'h0;
        au_b_o   = 4'h0;
        au_s1_o  = 1'b0;
        au_s0_o  = 1'b0;
        au_cin_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = opa_i;
                    b_d     = opb_i;
                    sel_d   = op_i[2:1];
                    carry_d = op_i[0];
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                au_a_o   = a_q[base +: 4];
                au_b_o   = b_q[base +: 4];
                au_s1_o  = sel_q[1];
                au_s0_o  = sel_q[0];
                au_cin_o = carry_q;
                result_d[base +: 4] = au_s_i;
                carry_d  = au_cout_i;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    fc_d    = au_cout_i;
                    fz_d    = ~|result_d;
                    fv_d    = (a_q[W-1] ^ au_s_i[3]) & (beff_msb ^ au_s_i[3]);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 2'b00;
            carry_q  <= 1'b0;
            result_q <= '0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            fv_q     <= fv_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign flag_c_o = fc_q;
    assign flag_z_o = fz_q;
    assign flag_v_o = fv_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench for nibble_serial_alu_ctrl: a 4-bit adder unit model, a whole-word arithmetic
// reference model, and directed operations with hand-computed results.
module tb_nibble_serial_alu_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opa, opb;
    logic         ready, done, flag_c, flag_z, flag_v;
    logic [W-1:0] result;
    logic         au_s1, au_s0, au_cin, au_cout;
    logic [3:0]   au_a, au_b, au_s, beff4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .opa_i(opa), .opb_i(opb), .ready_o(ready), .done_o(done),
        .result_o(result), .flag_c_o(flag_c), .flag_z_o(flag_z), .flag_v_o(flag_v),
        .au_s1_o(au_s1), .au_s0_o(au_s0), .au_a_o(au_a), .au_b_o(au_b),
        .au_cin_o(au_cin), .au_s_i(au_s), .au_cout_i(au_cout)
    );

    // the shared 4-bit unit
    always_comb begin
        beff4 = 4'h0;
        case ({au_s1, au_s0})
            2'b00:   beff4 = au_b;
            2'b01:   beff4 = ~au_b;
            2'b10:   beff4 = 4'h0;
            default: beff4 = 4'hF;
        endcase
        {au_cout, au_s} = 5'(au_a) + 5'(beff4) + 5'(au_cin);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: whole-word arithmetic plus a phase count (0 idle, 1..N run, N+1 done)
    int           phase = 0;
    logic [W-1:0] ma = '0, mb = '0, mbe = '0, m_res = '0;
    logic [1:0]   msel = '0;
    logic         mcin = 0, m_c = 0, m_z = 0, m_v = 0;
    logic [W:0]   sum;

    function automatic logic [W-1:0] beff_word(input logic [W-1:0] b, input logic [1:0] sel);
        case (sel)
            2'b00:   return b;
            2'b01:   return ~b;
            2'b10:   return '0;
            default: return '1;
        endcase
    endfunction

    function automatic logic carry_into(input int p);
        logic [31:0] mask, s;
        if (p == 0) return mcin;
        mask = (32'h1 << (4 * p)) - 32'h1;
        s = (32'(ma) & mask) + (32'(mbe) & mask) + 32'(mcin);
        return s[4*p];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase = 0; m_res = '0; m_c = 0; m_z = 0; m_v = 0;
        end else if (phase == 0) begin
            if (start) begin
                ma = opa; mb = opb; msel = op[2:1]; mcin = op[0];
                mbe = beff_word(opb, op[2:1]);
                phase = 1;
            end
        end else if (phase < N) begin
            phase++;
        end else if (phase == N) begin
            sum   = (W+1)'(ma) + (W+1)'(mbe) + (W+1)'(mcin);
            m_res = sum[W-1:0];
            m_c   = sum[W];
            m_z   = (m_res == '0);
            m_v   = (ma[W-1] == mbe[W-1]) && (m_res[W-1] != ma[W-1]);
            phase = N + 1;
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(ready), 32'(phase == 0));
            check("done", 32'(done), 32'(phase == N + 1));
            if (phase >= 1 && phase <= N) begin
                check("au_a", 32'(au_a), 32'(ma[4*(phase-1) +: 4]));
                check("au_b", 32'(au_b), 32'(mb[4*(phase-1) +: 4]));
                check("au_sel", 32'({au_s1, au_s0}), 32'(msel));
                check("au_cin", 32'(au_cin), 32'(carry_into(phase - 1)));
            end else begin
                check("au_idle", 32'({au_a, au_b, au_s1, au_s0, au_cin}), 32'h0);
                check("result", 32'(result), 32'(m_res));
                check("flags", 32'({flag_c, flag_z, flag_v}), 32'({m_c, m_z, m_v}));
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r,
                          input logic ec, input logic ez, input logic ev);
        int lat;
        bit got;
        @(posedge clk); #2;
        opa = a; opb = b; op = o; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; opa = ~a; opb = b ^ 16'h5A5A; op = ~o;
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(N));
        check({name, "_result"}, 32'(result), 32'(exp_r));
        check({name, "_flags"}, 32'({flag_c, flag_z, flag_v}), 32'({ec, ez, ev}));
    endtask

    int ndone;

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #2 chk_en = 1;
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'h0);
        check("reset_flags", 32'({flag_c, flag_z, flag_v}), 32'h0);

        run_op("add",    3'b000, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("sub",    3'b011, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("inc",    3'b101, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("dec",    3'b110, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        run_op("add_ov", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_op("tfr0",   3'b100, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("add1",   3'b001, 16'h00FF, 16'h0F00, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("ones",   3'b111, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0);

        // second request during RUN must be dropped
        @(posedge clk); #2;
        opa = 16'h1234; opb = 16'h0FFF; op = 3'b000; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        opa = 16'hFFFF; opb = 16'hFFFF; op = 3'b001; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("busy_start_dones", 32'(ndone), 32'd1);
        check("busy_start_result", 32'(result), 32'h2233);

        // reset during the second RUN cycle
        @(posedge clk); #2;
        opa = 16'h1111; opb = 16'h2222; op = 3'b000; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_result", 32'(result), 32'h0);
        check("abort_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        run_op("post_abort", 3'b000, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);

        @(posedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
